// File: rtl/starship_pkg.sv
// Shared starship package: state encodings, spawner parameter defaults,
// LFSR tap mask and lane index constants, plus a small one-hot helper.
// Ports: none (package only).
package starship_pkg;

   // Spawner control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } spawner_state_t;

   // Parameter defaults for the monster spawner
   localparam logic [15:0] DEF_LFSR_SEED        = 16'hACE1;
   localparam int          DEF_INIT_INTERVAL    = 40;
   localparam int          DEF_MIN_INTERVAL     = 10;
   localparam int          DEF_STEP             = 2;
   localparam int          DEF_SPAWNS_PER_LEVEL = 8;

   // Feedback taps for x^16+x^14+x^13+x^11+1 in a left-shifting register
   // (bits 15, 13, 12, 10 of the current value)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Lane indices as seen on monster_busy / spawn_req
   localparam logic [1:0] LANE_TOP    = 2'd0;
   localparam logic [1:0] LANE_BOTTOM = 2'd1;
   localparam logic [1:0] LANE_LEFT   = 2'd2;
   localparam logic [1:0] LANE_RIGHT  = 2'd3;

   // Saturation limits
   localparam logic [3:0] LEVEL_MAX = 4'd15;
   localparam logic [7:0] COUNT_MAX = 8'd255;

   // Converts a lane index into its spawn_req bit
   function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/monster_spawner_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used as the spawner's random source.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, loads SEED
//   q    - current register value
module lfsr16
   import starship_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   // Shifts every cycle with the XOR of the tapped bits entering at bit 0.
   // The all-zero value is a lock-up state for an XOR LFSR, so it is
   // recovered by reloading the seed rather than shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= SEED;
      end else if (q == 16'h0000) begin
         q <= SEED;
      end else begin
         q <= {q[14:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/monster_spawner.sv
// monster_spawner: times monster spawn events, picks a free lane using an
// LFSR, and raises difficulty as spawns accumulate.
// Ports:
//   timerClk     - clock
//   Reset        - asynchronous active-high reset
//   play_flag    - game start request
//   game_over    - OR of all monster controllers' game_over
//   monster_busy - per-lane monster present (0 top, 1 bottom, 2 left, 3 right)
//   spawn_req    - registered one-hot spawn pulse per lane
//   level        - current difficulty level (saturates at 15)
//   spawn_count  - spawns issued this game (saturates at 255)
module monster_spawner
   import starship_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED        = DEF_LFSR_SEED,
   parameter int          INIT_INTERVAL    = DEF_INIT_INTERVAL,
   parameter int          MIN_INTERVAL     = DEF_MIN_INTERVAL,
   parameter int          STEP             = DEF_STEP,
   parameter int          SPAWNS_PER_LEVEL = DEF_SPAWNS_PER_LEVEL
) (
   input  logic       timerClk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       game_over,
   input  logic [3:0] monster_busy,
   output logic [3:0] spawn_req,
   output logic [3:0] level,
   output logic [7:0] spawn_count
);

   spawner_state_t state, state_nxt;

   logic [15:0] lfsr_q;
   logic        lfsr_unused;
   logic [7:0]  tick_cnt;
   logic [7:0]  level_spawns;
   logic [11:0] level_dec;
   logic [7:0]  interval;
   logic        spawn_event;
   logic [1:0]  candidate;
   logic [1:0]  scan_idx;
   logic [1:0]  lane_sel;
   logic        lane_found;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (timerClk),
      .rst (Reset),
      .q   (lfsr_q)
   );

   // Only the two low LFSR bits pick a lane; the rest is folded here so the
   // remaining bits are visibly consumed.
   assign lfsr_unused = ^lfsr_q[15:2];
   assign candidate   = lfsr_q[1:0];

   // State register for the IDLE/RUN/HALT controller.
   always_ff @(posedge timerClk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. game_over is checked before anything else in RUN so
   // a game ending on a spawn cycle never produces that spawn.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (play_flag) state_nxt = RUN;
         RUN:     if (game_over) state_nxt = HALT;
         HALT:    if (!game_over && !play_flag) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Spawn interval shrinks by STEP per level down to MIN_INTERVAL. The
   // subtraction is only taken when it cannot drop below the clamp, so a
   // large level*STEP never wraps around.
   always_comb begin
      level_dec = 12'(level) * 12'(STEP);
      if (12'(INIT_INTERVAL) > level_dec + 12'(MIN_INTERVAL)) begin
         interval = 8'(12'(INIT_INTERVAL) - level_dec);
      end else begin
         interval = 8'(MIN_INTERVAL);
      end
   end

   assign spawn_event = (state == RUN) && !game_over && (tick_cnt == interval - 8'd1);

   // Lane choice: starting at the random candidate, take the first lane
   // without a monster, wrapping around through all four lanes.
   always_comb begin
      lane_found = 1'b0;
      lane_sel   = candidate;
      scan_idx   = candidate;
      for (int i = 0; i < 4; i++) begin
         scan_idx = candidate + 2'(i);
         if (!lane_found && !monster_busy[scan_idx]) begin
            lane_found = 1'b1;
            lane_sel   = scan_idx;
         end
      end
   end

   // Tick counter, spawn pulse and difficulty bookkeeping. Counters clear
   // when a game starts and are simply held in IDLE and HALT. A spawn event
   // with every lane occupied still restarts the tick counter but issues
   // nothing and counts nothing. Level changes only affect the interval
   // compare, so the new interval takes hold from the next event onward.
   always_ff @(posedge timerClk or posedge Reset) begin
      if (Reset) begin
         tick_cnt     <= '0;
         spawn_req    <= '0;
         level        <= '0;
         spawn_count  <= '0;
         level_spawns <= '0;
      end else begin
         spawn_req <= '0;
         if (state == IDLE && play_flag) begin
            tick_cnt     <= '0;
            level        <= '0;
            spawn_count  <= '0;
            level_spawns <= '0;
         end else if (spawn_event) begin
            tick_cnt <= '0;
            if (lane_found) begin
               spawn_req <= lane_onehot(lane_sel);
               if (spawn_count != COUNT_MAX) begin
                  spawn_count <= spawn_count + 8'd1;
               end
               if (level_spawns == 8'(SPAWNS_PER_LEVEL - 1)) begin
                  level_spawns <= '0;
                  if (level != LEVEL_MAX) begin
                     level <= level + 4'd1;
                  end
               end else begin
                  level_spawns <= level_spawns + 8'd1;
               end
            end
         end else if (state == RUN && !game_over) begin
            tick_cnt <= tick_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/monster_spawner.md
MONSTER_SPAWNER -- requirements
Module: monster_spawner

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-002 SHALL have parameter INIT_INTERVAL, default 40, timerClk ticks between spawn events at level 0.
REQ-003 SHALL have parameter MIN_INTERVAL, default 10, lower clamp on spawn interval.
REQ-004 SHALL have parameter STEP, default 2, interval decrease per level.
REQ-005 SHALL have parameter SPAWNS_PER_LEVEL, default 8, issued spawns per level increment.
REQ-006 SHALL have port timerClk  in  1  clock; reset Reset, asynchronous, active-high; clock timerClk.
REQ-007 SHALL have port Reset  in  1  asynchronous active-high reset.
REQ-008 SHALL have port play_flag  in  1  game start request.
REQ-009 SHALL have port game_over  in  1  OR of all monster controllers' game_over.
REQ-010 SHALL have port monster_busy  in  4  per-lane monster present (bit 0 top, bit 1 bottom, bit 2 left, bit 3 right).
REQ-011 SHALL have port spawn_req  out  4  one-hot spawn pulse per lane (bit 1 drives btm_random).
REQ-012 SHALL have port level  out  4  current difficulty level.
REQ-013 SHALL have port spawn_count  out  8  spawns issued this game.

Function
REQ-014 SHALL implement states IDLE, RUN, HALT.
REQ-015 IDLE->RUN when play_flag=1; on entry tick_cnt, level, spawn_count, and the per-level spawn counter SHALL clear to 0.
REQ-016 RUN->HALT when game_over=1; game_over SHALL take priority over a same-cycle spawn event (no pulse, no count).
REQ-017 HALT->IDLE when game_over=0 and play_flag=0; HALT SHALL hold level and spawn_count; spawn_req=0.
REQ-018 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL shift every cycle in all states; it SHALL reload LFSR_SEED if it ever reads zero.
REQ-019 interval SHALL equal max(INIT_INTERVAL - level*STEP, MIN_INTERVAL), computed at 8 bits without underflow.
REQ-020 In RUN, 8-bit tick_cnt SHALL increment each cycle; a spawn event SHALL occur when tick_cnt == interval-1, and tick_cnt SHALL then return to 0.
REQ-021 On a spawn event, candidate = lfsr[1:0]; the lane SHALL be the first non-busy lane scanning candidate, +1, +2, +3 mod 4 (wrap).
REQ-022 If all four lanes are busy, no spawn SHALL issue and counters other than tick_cnt SHALL be unchanged.
REQ-023 spawn_req SHALL be registered: one-hot on the chosen lane for exactly one timerClk cycle, the cycle after the event; otherwise 0.
REQ-024 Each issued spawn SHALL increment spawn_count (saturate 255) and the per-level counter; the counter reaching SPAWNS_PER_LEVEL SHALL clear it and increment level (saturate 15).
REQ-025 An interval change SHALL apply from the next spawn event; tick_cnt is not reset by the level change.

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE, lfsr=LFSR_SEED, tick_cnt=0, spawn_req=0, level=0, spawn_count=0, per-level counter=0.
REQ-027 Reset asserted mid-RUN SHALL zero spawn_req in the same cycle, with no pulse completion.

Structure
REQ-028 State encodings, parameter defaults, LFSR tap constant, and lane index constants SHALL live in the shared starship package.
REQ-029 The LFSR SHALL be a sub-module lfsr16 (ports clk, rst, q[15:0]); the remainder SHALL be a single module.

Verification
REQ-030 Reset pulse -> spawn_req=0, level=0, spawn_count=0, state IDLE, lfsr=16'hACE1.
REQ-031 play_flag=1, monster_busy=0 -> first spawn_req one-hot 40 cycles after RUN entry, repeating every 40; spawn_count increments each pulse.
REQ-032 monster_busy=4'b1111 for 200 cycles in RUN -> spawn_req never asserts, spawn_count stays 0.
REQ-033 monster_busy=4'b1110 -> every spawn_req = 4'b0001 for any lfsr[1:0] (wrap scan).
REQ-034 Free run, no busy -> level=1 after 8 spawns, with interval 38 thereafter; level saturates at 15, interval 10, spawn_count saturates at 255.
REQ-035 game_over on the spawn-event cycle -> no pulse, HALT, counts held; drop game_over and play_flag -> IDLE; Reset mid-RUN -> all outputs 0 immediately.
